// File: rtl/rom_bootloader.sv
// ROM image loader: takes 32-bit host words over a 4-phase req/ack handshake
// and writes them MSB-first as byte strobes into the ROM region of SRAM.
module rom_bootloader #(
    parameter int                ADDR_W      = 19,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TOTAL_BYTES = 49152,
    parameter int                WR_PULSE    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       host_bootdata,
    input  logic              host_bootdata_req,
    output logic              host_bootdata_ack,
    output logic              host_rom_initialised,
    output logic [ADDR_W-1:0] romwrite_addr,
    output logic [7:0]        romwrite_data,
    output logic              romwrite_wr
);

    localparam int CW = ADDR_W + 1;
    localparam int PW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
    localparam logic [CW-1:0] LAST  = CW'(TOTAL_BYTES);
    localparam logic [PW-1:0] PLAST = PW'(WR_PULSE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RELEASE
    } state_t;

    state_t            state, state_n;
    logic [31:0]       word, word_n;
    logic [1:0]        idx, idx_n;
    logic [CW-1:0]     cnt, cnt_n, cnt_inc;
    logic [PW-1:0]     pulse, pulse_n;
    logic              ack_n, init_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        data_n;

    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    pick = w[31:24];
            2'd1:    pick = w[23:16];
            2'd2:    pick = w[15:8];
            default: pick = w[7:0];
        endcase
    endfunction

    assign cnt_inc     = cnt + CW'(1);
    assign romwrite_wr = (state == STROBE);

    always_comb begin
        state_n = state;
        word_n  = word;
        idx_n   = idx;
        cnt_n   = cnt;
        pulse_n = pulse;
        ack_n   = host_bootdata_ack;
        init_n  = host_rom_initialised;
        addr_n  = romwrite_addr;
        data_n  = romwrite_data;
        case (state)
            IDLE: begin
                if (host_bootdata_req && !host_bootdata_ack) begin
                    word_n = host_bootdata;
                    ack_n  = 1'b1;
                    idx_n  = 2'd0;
                    // once loaded, further words are acknowledged but dropped
                    if (host_rom_initialised) begin
                        state_n = RELEASE;
                    end else begin
                        state_n = SETUP;
                        addr_n  = BASE_ADDR + cnt[ADDR_W-1:0];
                        data_n  = host_bootdata[31:24];
                    end
                end
            end
            SETUP: begin
                state_n = STROBE;
                pulse_n = '0;
            end
            STROBE: begin
                if (pulse == PLAST) state_n = HOLD;
                else pulse_n = pulse + PW'(1);
            end
            HOLD: begin
                cnt_n = cnt_inc;
                if (cnt_inc == LAST) begin
                    init_n  = 1'b1;
                    state_n = RELEASE;
                end else if (idx != 2'd3) begin
                    idx_n   = idx + 2'd1;
                    state_n = SETUP;
                    addr_n  = BASE_ADDR + cnt_inc[ADDR_W-1:0];
                    data_n  = pick(word, idx + 2'd1);
                end else begin
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (!host_bootdata_req) begin
                    ack_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            word                 <= '0;
            idx                  <= '0;
            cnt                  <= '0;
            pulse                <= '0;
            host_bootdata_ack    <= 1'b0;
            host_rom_initialised <= 1'b0;
            romwrite_addr        <= '0;
            romwrite_data        <= '0;
        end else begin
            state                <= state_n;
            word                 <= word_n;
            idx                  <= idx_n;
            cnt                  <= cnt_n;
            pulse                <= pulse_n;
            host_bootdata_ack    <= ack_n;
            host_rom_initialised <= init_n;
            romwrite_addr        <= addr_n;
            romwrite_data        <= data_n;
        end
    end

endmodule

// File: tb/tb_rom_bootloader.sv
// Randomised bench for rom_bootloader: a byte-stream model predicts every
// SRAM write, which a bus monitor captures together with strobe timing.
module tb_rom_bootloader;

    localparam int AW    = 19;
    localparam int BASE  = 'h7FFF9;
    localparam int TOTAL = 14;
    localparam int WP    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   bootdata = '0;
    logic          req = 1'b0;
    logic          ack;
    logic          init;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          wr;

    rom_bootloader #(
        .ADDR_W     (AW),
        .BASE_ADDR  (AW'(BASE)),
        .TOTAL_BYTES(TOTAL),
        .WR_PULSE   (WP)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .host_bootdata       (bootdata),
        .host_bootdata_req   (req),
        .host_bootdata_ack   (ack),
        .host_rom_initialised(init),
        .romwrite_addr       (addr),
        .romwrite_data       (data),
        .romwrite_wr         (wr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int a;
        int d;
        int w;
        bit st;
    } wr_t;

    wr_t mon_q[$];

    // bus monitor: records each strobe with width and addr/data stability
    // from the setup cycle through the hold cycle
    bit            m_prev = 0;
    int            m_w = 0;
    bit            m_st = 0;
    logic [AW-1:0] m_a = '0, m_pa = '0;
    logic [7:0]    m_d = '0, m_pd = '0;

    always @(negedge clk) begin
        if (reset) begin
            m_prev = 0;
            m_w = 0;
        end else begin
            if (wr && !m_prev) begin
                m_w = 1;
                m_a = addr;
                m_d = data;
                m_st = (addr == m_pa) && (data == m_pd);
            end else if (wr && m_prev) begin
                m_w++;
                if (addr != m_a || data != m_d) m_st = 0;
            end else if (!wr && m_prev) begin
                if (addr != m_a || data != m_d) m_st = 0;
                mon_q.push_back('{int'(m_a), int'(m_d), m_w, m_st});
            end
            m_prev = wr;
        end
        m_pa = addr;
        m_pd = data;
    end

    int m_cnt = 0;
    bit m_init = 0;

    task automatic send_word(input logic [31:0] w, input int mode);
        wr_t exp_q[$];
        int cyc;
        int nb;
        wr_t o;
        if (!m_init) begin
            for (int i = 0; i < 4; i++) begin
                if (!m_init) begin
                    exp_q.push_back('{(BASE + m_cnt) % (1 << AW),
                                      int'((w >> (8 * (3 - i))) & 32'hFF), WP, 1'b1});
                    m_cnt++;
                    if (m_cnt == TOTAL) m_init = 1;
                end
            end
        end
        nb = exp_q.size();
        @(negedge clk);
        bootdata = w;
        req = 1'b1;
        @(posedge clk);
        #1;
        chk("ack_rise", ack, 1'b1);
        if (mode == 1) begin
            repeat (4 * nb + 12) @(posedge clk);
            #1;
            chk("ack_held", ack, 1'b1);
            req = 1'b0;
        end else if (mode == 2 && nb > 0) begin
            req = 1'b0;
            @(posedge clk);
            #1;
            req = 1'b1;
            repeat (4 * nb) @(posedge clk);
            #1;
            chk("ack_glitch", ack, 1'b1);
            req = 1'b0;
        end else begin
            req = 1'b0;
        end
        cyc = 1;
        for (int g = 0; g < 400; g++) begin
            @(posedge clk);
            #1;
            if (!ack) break;
            cyc++;
        end
        chk("ack_fall", ack, 1'b0);
        if (mode == 0) chk("ack_len", cyc, 4 * nb + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("ack_idle", ack, 1'b0);
        chk("n_writes", mon_q.size(), nb);
        while (mon_q.size() > 0 && exp_q.size() > 0) begin
            o = mon_q.pop_front();
            chk("wr_addr", o.a, exp_q[0].a);
            chk("wr_data", o.d, exp_q[0].d);
            chk("wr_width", o.w, WP);
            chk("wr_stable", o.st, 1'b1);
            void'(exp_q.pop_front());
        end
        mon_q.delete();
        chk("init", init, m_init);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_wr", wr, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_addr", addr, '0);
        chk("rst_data", data, '0);
        chk("rst_init", init, 1'b0);
        req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_cnt = 0;
        m_init = 0;
        mon_q.delete();
    endtask

    initial begin
        int rises;
        bit pw;
        #2;
        do_reset();

        send_word(32'hF301897F, 0);

        // abort inside the second byte's strobe
        @(negedge clk);
        bootdata = $urandom;
        req = 1'b1;
        rises = 0;
        pw = 0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (wr && !pw) rises++;
            pw = wr;
            if (rises == 2) break;
        end
        chk("mid_strobe", rises, 2);
        chk("mid_wr", wr, 1'b1);
        #2;
        do_reset();

        send_word($urandom, 0);
        send_word($urandom, 1);
        send_word($urandom, 2);
        send_word($urandom, int'($urandom_range(0, 2)));
        chk("loaded", init, 1'b1);

        send_word(32'hDEADBEEF, 0);
        send_word($urandom, 1);
        send_word($urandom, 0);
        chk("still_loaded", init, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
